sigdel_cic_decimator: RTL and testbench

Third-order CIC (sinc³) decimator recovering a signed multi-bit sample stream from a single-bit sigma-delta bitstream. It sits on the modulator side of the slice datapath. It consumes the output of `second_order_sigdel`, or any of the `external_sigma_delta_streams` bits, on the same clock that drives the modulator. It delivers full-scale 24-bit words through a valid/ready handshake, for logging or comparison against `log_value_reconstructed`.

---
 rtl/sigdel_cic_decimator.sv | 177 +++++++++++++++++
 tb/tb_sigdel_cic_decimator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sigdel_cic_decimator.sv
// ---------------------------------------------------------------------------
// sigdel_cic_decimator
//
// Third-order CIC (sinc^3) decimator. Turns a single-bit sigma-delta
// bitstream (1 -> +1, 0 -> -1) into signed OUTPUT_WIDTH-bit words at
// 1/R of the input rate, R = 2**DECIMATION_LOG2, delivered through a
// valid/ready handshake.
//
// Parameters
//   DECIMATION_LOG2 : log2 of the decimation ratio (legal 2..7)
//   OUTPUT_WIDTH    : output word width, >= 2 + 3*DECIMATION_LOG2
//
// Ports
//   clock        : single rising-edge clock (modulator rate)
//   reset        : synchronous, active-low; clears every register
//   enable       : consume one bitstream sample this clock
//   bitstream_in : modulator output bit
//   data_out     : decimated sample, stable while data_valid is high
//   data_valid   : sample available
//   data_ready   : consumer accepts the sample this clock
//   saturated    : the held data_out was clipped to positive full scale
//   overrun      : sticky; a new sample was dropped because the held one
//                  had not been accepted
// ---------------------------------------------------------------------------
module sigdel_cic_decimator #(
    parameter int DECIMATION_LOG2 = 6,
    parameter int OUTPUT_WIDTH    = 24
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           bitstream_in,
    output logic signed [OUTPUT_WIDTH-1:0] data_out,
    output logic                           data_valid,
    input  logic                           data_ready,
    output logic                           saturated,
    output logic                           overrun
);

    // Internal modulo width: the comb output spans +/-2^(3*log2 R), which
    // needs 3*log2 R + 2 bits. Integrators are allowed to wrap at this width;
    // the comb differences undo the wrap.
    localparam int W     = 2 + 3 * DECIMATION_LOG2;
    localparam int SHIFT = OUTPUT_WIDTH - 1 - 3 * DECIMATION_LOG2;
    localparam int EXT_W = OUTPUT_WIDTH + 1;

    localparam logic [DECIMATION_LOG2-1:0] CNT_LAST = '1;

    localparam logic signed [EXT_W-1:0] POS_MAX = {2'b00, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] NEG_MIN = {2'b11, {(OUTPUT_WIDTH-1){1'b0}}};

    // Sign-extend the comb result, scale it to full output range and clip.
    // Returns {clipped_flag, word}. Only +2^(3*log2 R) can exceed the
    // positive limit; the most negative value lands exactly on -2^(OW-1)
    // and is not a clip.
    function automatic logic [OUTPUT_WIDTH:0] scale_sat(input logic signed [W-1:0] c);
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] shifted;
        ext     = EXT_W'(c);
        shifted = ext <<< SHIFT;
        if (shifted > POS_MAX) begin
            scale_sat = {1'b1, POS_MAX[OUTPUT_WIDTH-1:0]};
        end else if (shifted < NEG_MIN) begin
            scale_sat = {1'b1, NEG_MIN[OUTPUT_WIDTH-1:0]};
        end else begin
            scale_sat = {1'b0, shifted[OUTPUT_WIDTH-1:0]};
        end
    endfunction

    // ------------------------------------------------------------------
    // Stage p0: integrators and decimation counter (input rate)
    // ------------------------------------------------------------------
    logic signed [W-1:0]          x_step;
    logic signed [W-1:0]          i1_p0, i2_p0, i3_p0;
    logic signed [W-1:0]          i1_nxt, i2_nxt, i3_nxt;
    logic [DECIMATION_LOG2-1:0]   dec_cnt_p0;
    logic                         dec_event;

    assign x_step    = bitstream_in ? W'(1) : {W{1'b1}};
    assign dec_event = enable && (dec_cnt_p0 == CNT_LAST);

    // The three integrators are chained within one clock: each one adds
    // the freshly updated value of the one before it.
    always_comb begin
        i1_nxt = i1_p0 + x_step;
        i2_nxt = i2_p0 + i1_nxt;
        i3_nxt = i3_p0 + i2_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            i1_p0      <= '0;
            i2_p0      <= '0;
            i3_p0      <= '0;
            dec_cnt_p0 <= '0;
        end else if (enable) begin
            i1_p0      <= i1_nxt;
            i2_p0      <= i2_nxt;
            i3_p0      <= i3_nxt;
            dec_cnt_p0 <= dec_cnt_p0 + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage p1: comb section, one step per decimation event
    // ------------------------------------------------------------------
    logic signed [W-1:0] d1_p1, d2_p1, d3_p1;
    logic signed [W-1:0] c1, c2, c3;
    logic signed [W-1:0] c3_p1;
    logic                vld_p1;
    logic [1:0]          warm_cnt;

    // The comb works on the integrator value that includes the sample
    // consumed on the decimation clock itself.
    always_comb begin
        c1 = i3_nxt - d1_p1;
        c2 = c1 - d2_p1;
        c3 = c2 - d3_p1;
    end

    // The first three comb outputs are built from half-filled delay lines
    // and are dropped; warm_cnt parks at 3 until the next reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            d1_p1    <= '0;
            d2_p1    <= '0;
            d3_p1    <= '0;
            c3_p1    <= '0;
            vld_p1   <= 1'b0;
            warm_cnt <= 2'd0;
        end else begin
            vld_p1 <= 1'b0;
            if (dec_event) begin
                d1_p1 <= i3_nxt;
                d2_p1 <= c1;
                d3_p1 <= c2;
                c3_p1 <= c3;
                if (warm_cnt == 2'd3) begin
                    vld_p1 <= 1'b1;
                end else begin
                    warm_cnt <= warm_cnt + 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage p2: scaling, saturation and output handshake
    // ------------------------------------------------------------------
    logic [OUTPUT_WIDTH:0] scaled_p1;

    assign scaled_p1 = scale_sat(c3_p1);

    // A new word may load when the slot is empty or is being emptied on
    // this same clock; otherwise the held word wins and the new one is lost.
    always_ff @(posedge clock) begin
        if (!reset) begin
            data_out   <= '0;
            saturated  <= 1'b0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (vld_p1) begin
                if (!data_valid || data_ready) begin
                    data_out   <= $signed(scaled_p1[OUTPUT_WIDTH-1:0]);
                    saturated  <= scaled_p1[OUTPUT_WIDTH];
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sigdel_cic_decimator.sv
// ---------------------------------------------------------------------------
// tb_sigdel_cic_decimator
//
// Directed bench for sigdel_cic_decimator at default parameters (R = 64,
// 24-bit output). The bitstream is a 4-sample periodic pattern indexed by
// the number of consumed samples, so every steady-state output equals
// R^3 * mean(pattern) scaled by 2^5, which is worked out by hand:
//   1111 -> +2^18 -> clips to 7FFFFF     0000 -> -2^18 -> 800000
//   0101 -> 0     -> 000000              0111 -> +2^17 -> 400000
//   0001 -> -2^17 -> C00000
// ---------------------------------------------------------------------------
module tb_sigdel_cic_decimator;

    localparam int L  = 6;
    localparam int OW = 24;

    logic          clk          = 1'b0;
    logic          reset        = 1'b0;
    logic          enable       = 1'b0;
    logic          bitstream_in = 1'b0;
    logic          data_ready   = 1'b0;
    logic [OW-1:0] data_out;
    logic          data_valid;
    logic          saturated;
    logic          overrun;

    int       checks   = 0;
    int       errors   = 0;
    int       idx      = 0;
    int       last_idx = 0;
    logic [3:0] pat    = 4'b1111;
    bit       rnd_en   = 1'b0;

    sigdel_cic_decimator #(
        .DECIMATION_LOG2(L),
        .OUTPUT_WIDTH   (OW)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .enable      (enable),
        .bitstream_in(bitstream_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .saturated   (saturated),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, count consumed samples at the
    // rising edge, return at the next falling edge for sampling.
    task automatic step();
        bitstream_in = pat[idx % 4];
        if (rnd_en) enable = 1'($urandom_range(0, 1));
        last_idx = idx;
        @(posedge clk);
        if (enable && reset) idx++;
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while (!data_valid && edges < budget);
        if (!data_valid) chk("valid_timeout", 32'(data_valid), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idx   = 0;
    endtask

    initial begin
        int e;
        int nvalid;
        int exp_idx;

        // Reset held with random inputs
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            enable       = 1'($urandom_range(0, 1));
            bitstream_in = 1'($urandom_range(0, 1));
            data_ready   = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            chk("rst_valid", 32'(data_valid), 32'd0);
        end
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_sat", 32'(saturated), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Constant +1: first word 257 clocks after release, clipped
        enable = 1'b1; data_ready = 1'b1; pat = 4'b1111; idx = 0;
        reset = 1'b1;
        wait_valid(400, e);
        chk("pos_latency", 32'(e), 32'd257);
        chk("pos_data", 32'(data_out), 32'h7FFFFF);
        chk("pos_sat", 32'(saturated), 32'd1);
        step();
        chk("pos_valid_fall", 32'(data_valid), 32'd0);
        wait_valid(100, e);
        chk("pos_period", 32'(e), 32'd63);
        chk("pos_data2", 32'(data_out), 32'h7FFFFF);

        // Constant -1: most negative word, not a clip
        pat = 4'b0000;
        do_reset();
        wait_valid(400, e);
        chk("neg_latency", 32'(e), 32'd257);
        chk("neg_data", 32'(data_out), 32'h800000);
        chk("neg_sat", 32'(saturated), 32'd0);
        step();
        wait_valid(100, e);
        chk("neg_data2", 32'(data_out), 32'h800000);
        chk("neg_sat2", 32'(saturated), 32'd0);

        // Alternating 1,0,1,0 -> zero
        pat = 4'b0101;
        do_reset();
        wait_valid(400, e);
        chk("alt_data", 32'(data_out), 32'h000000);
        chk("alt_sat", 32'(saturated), 32'd0);
        step();
        wait_valid(100, e);
        chk("alt_data2", 32'(data_out), 32'h000000);

        // 3/4 ones -> +half scale, 1/4 ones -> -half scale
        pat = 4'b0111;
        do_reset();
        wait_valid(400, e);
        chk("dc_pos_half", 32'(data_out), 32'h400000);
        chk("dc_pos_sat", 32'(saturated), 32'd0);
        pat = 4'b0001;
        do_reset();
        wait_valid(400, e);
        chk("dc_neg_half", 32'(data_out), 32'hC00000);
        chk("dc_overrun", 32'(overrun), 32'd0);

        // Backpressure across two decimation events
        pat = 4'b1111; data_ready = 1'b0;
        do_reset();
        wait_valid(400, e);
        chk("bp_first", 32'(data_out), 32'h7FFFFF);
        chk("bp_overrun0", 32'(overrun), 32'd0);
        pat = 4'b0000;
        repeat (63) step();
        chk("bp_before_ovr", 32'(overrun), 32'd0);
        chk("bp_still_valid", 32'(data_valid), 32'd1);
        step();
        chk("bp_overrun1", 32'(overrun), 32'd1);
        chk("bp_held_data", 32'(data_out), 32'h7FFFFF);
        chk("bp_held_sat", 32'(saturated), 32'd1);
        data_ready = 1'b1;
        step();
        chk("bp_after_xfer", 32'(data_valid), 32'd0);
        chk("bp_ovr_sticky", 32'(overrun), 32'd1);
        repeat (70) step();
        chk("bp_ovr_sticky2", 32'(overrun), 32'd1);

        // Reset for one clock while a word is held
        data_ready = 1'b0;
        wait_valid(100, e);
        chk("mid_valid_before", 32'(data_valid), 32'd1);
        reset = 1'b0;
        step();
        chk("mid_rst_valid", 32'(data_valid), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'd0);
        chk("mid_rst_sat", 32'(saturated), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1; idx = 0;
        wait_valid(400, e);
        chk("mid_warmup", 32'(e), 32'd257);
        chk("mid_data", 32'(data_out), 32'h800000);

        // Random enable gaps: period counted in consumed samples
        data_ready = 1'b1; pat = 4'b0111;
        do_reset();
        rnd_en  = 1'b1;
        nvalid  = 0;
        exp_idx = 256;
        for (int s = 0; s < 3000 && nvalid < 5; s++) begin
            step();
            if (data_valid) begin
                chk("gap_data", 32'(data_out), 32'h400000);
                chk("gap_period", 32'(last_idx), 32'(exp_idx));
                exp_idx += 64;
                nvalid++;
            end
        end
        chk("gap_count", 32'(nvalid), 32'd5);
        rnd_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
